// File: rtl/uart_cpu_regs.sv
// rtl/uart_cpu_regs.sv - CPU register block of the FPGA UART (STAT, CTRL, TX, RX)
module uart_cpu_regs (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        wr_en_cpu_i,
    input  logic        rd_en_cpu_i,
    input  logic [1:0]  cpu_addr_i,
    input  logic [31:0] cpu_wr_data_i,
    output logic [31:0] cpu_rd_data_o,
    output logic        tx_en_o,
    output logic        tx_start_o,
    output logic [7:0]  tx_data_o,
    output logic [1:0]  tx_width_o,
    input  logic        tx_done_i,
    output logic        rx_en_o,
    output logic [1:0]  rx_width_o,
    input  logic        rx_valid_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_frame_err_i,
    output logic        irq_o
);
    localparam int CPU_ADDR_WIDTH = 2;
    localparam int CPU_DATA_WIDTH = 32;

    localparam logic [CPU_ADDR_WIDTH-1:0] ADDR_STAT = 2'd0;
    localparam logic [CPU_ADDR_WIDTH-1:0] ADDR_CTRL = 2'd1;
    localparam logic [CPU_ADDR_WIDTH-1:0] ADDR_TX   = 2'd2;
    localparam logic [CPU_ADDR_WIDTH-1:0] ADDR_RX   = 2'd3;

    function automatic logic [7:0] width_mask(input logic [1:0] width, input logic [7:0] data);
        case (width)
            2'b00:   width_mask = data & 8'h1F;
            2'b01:   width_mask = data & 8'h3F;
            2'b10:   width_mask = data & 8'h7F;
            default: width_mask = data;
        endcase
    endfunction

    logic                      r_tx_en, r_tx_irq_en, r_rx_en, r_rx_irq_en;
    logic [1:0]                r_tx_width, r_rx_width;
    logic [7:0]                r_tx_reg, r_tx_shadow, r_rx_hold;
    logic                      r_busy, r_tx_start, r_tx_done;
    logic                      r_rx_valid, r_rx_overrun, r_rx_frame_err;
    logic [CPU_DATA_WIDTH-1:0] r_rd_data;
    logic                      r_irq;

    logic                      w_wr_stat, w_wr_ctrl, w_wr_tx, w_rd_rx;
    logic                      w_start_acc, w_rx_load;
    logic                      w_busy_nxt, w_tx_done_nxt, w_rx_valid_nxt;
    logic                      w_overrun_nxt, w_frame_err_nxt;
    logic                      w_tx_irq_en_nxt, w_rx_irq_en_nxt;
    logic [CPU_DATA_WIDTH-1:0] w_rd_mux;
    logic                      w_unused_wdata;

    assign w_wr_stat = wr_en_cpu_i && (cpu_addr_i == ADDR_STAT);
    assign w_wr_ctrl = wr_en_cpu_i && (cpu_addr_i == ADDR_CTRL);
    assign w_wr_tx   = wr_en_cpu_i && (cpu_addr_i == ADDR_TX);
    assign w_rd_rx   = rd_en_cpu_i && (cpu_addr_i == ADDR_RX);

    // A start needs the same write to leave tx_en set, and the core idle.
    assign w_start_acc = w_wr_ctrl && cpu_wr_data_i[1] && cpu_wr_data_i[0] && !r_busy;
    assign w_rx_load   = rx_valid_i && r_rx_en;

    always_comb begin
        w_busy_nxt = r_busy;
        if (w_start_acc)
            w_busy_nxt = 1'b1;
        else if (w_wr_ctrl && !cpu_wr_data_i[0])
            w_busy_nxt = 1'b0;
        else if (tx_done_i)
            w_busy_nxt = 1'b0;
    end

    // Hardware sets beat W1C clears; an RX read racing a new byte keeps valid without overrun.
    assign w_tx_done_nxt   = tx_done_i || (r_tx_done && !(w_wr_stat && cpu_wr_data_i[0]));
    assign w_rx_valid_nxt  = w_rx_load || (r_rx_valid && !w_rd_rx);
    assign w_overrun_nxt   = (w_rx_load && r_rx_valid && !w_rd_rx)
                           || (r_rx_overrun && !(w_wr_stat && cpu_wr_data_i[3]));
    assign w_frame_err_nxt = (w_rx_load && rx_frame_err_i)
                           || (r_rx_frame_err && !(w_wr_stat && cpu_wr_data_i[4]));

    assign w_tx_irq_en_nxt = w_wr_ctrl ? cpu_wr_data_i[2]  : r_tx_irq_en;
    assign w_rx_irq_en_nxt = w_wr_ctrl ? cpu_wr_data_i[17] : r_rx_irq_en;

    always_comb begin
        w_rd_mux = '0;
        case (cpu_addr_i)
            ADDR_STAT: w_rd_mux = {27'd0, r_rx_frame_err, r_rx_overrun, r_rx_valid, r_busy, r_tx_done};
            ADDR_CTRL: w_rd_mux = {9'd0, r_rx_width, 3'd0, r_rx_irq_en, r_rx_en,
                                   9'd0, r_tx_width, 2'd0, r_tx_irq_en, 1'b0, r_tx_en};
            ADDR_TX:   w_rd_mux = {24'd0, r_tx_reg};
            ADDR_RX:   w_rd_mux = {24'd0, r_rx_hold};
            default:   w_rd_mux = '0;
        endcase
    end

    assign w_unused_wdata = &{1'b0, cpu_wr_data_i[31:23], cpu_wr_data_i[20:18],
                              cpu_wr_data_i[15:7], cpu_wr_data_i[4:3]};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_tx_en        <= 1'b0;
            r_tx_irq_en    <= 1'b0;
            r_tx_width     <= 2'b00;
            r_rx_en        <= 1'b0;
            r_rx_irq_en    <= 1'b0;
            r_rx_width     <= 2'b00;
            r_tx_reg       <= 8'h00;
            r_tx_shadow    <= 8'h00;
            r_rx_hold      <= 8'h00;
            r_busy         <= 1'b0;
            r_tx_start     <= 1'b0;
            r_tx_done      <= 1'b0;
            r_rx_valid     <= 1'b0;
            r_rx_overrun   <= 1'b0;
            r_rx_frame_err <= 1'b0;
            r_rd_data      <= '0;
            r_irq          <= 1'b0;
        end else begin
            if (w_wr_ctrl) begin
                r_tx_en     <= cpu_wr_data_i[0];
                r_tx_irq_en <= cpu_wr_data_i[2];
                r_tx_width  <= cpu_wr_data_i[6:5];
                r_rx_en     <= cpu_wr_data_i[16];
                r_rx_irq_en <= cpu_wr_data_i[17];
                r_rx_width  <= cpu_wr_data_i[22:21];
            end
            if (w_wr_tx)
                r_tx_reg <= cpu_wr_data_i[7:0];
            if (w_start_acc)
                r_tx_shadow <= width_mask(cpu_wr_data_i[6:5], r_tx_reg);
            if (w_rx_load)
                r_rx_hold <= width_mask(r_rx_width, rx_data_i);
            if (rd_en_cpu_i)
                r_rd_data <= w_rd_mux;

            r_tx_start     <= w_start_acc;
            r_busy         <= w_busy_nxt;
            r_tx_done      <= w_tx_done_nxt;
            r_rx_valid     <= w_rx_valid_nxt;
            r_rx_overrun   <= w_overrun_nxt;
            r_rx_frame_err <= w_frame_err_nxt;
            r_irq          <= (w_tx_done_nxt && w_tx_irq_en_nxt) || (w_rx_valid_nxt && w_rx_irq_en_nxt);
        end
    end

    assign cpu_rd_data_o = r_rd_data;
    assign tx_en_o       = r_tx_en;
    assign tx_start_o    = r_tx_start;
    assign tx_data_o     = r_tx_shadow;
    assign tx_width_o    = r_tx_width;
    assign rx_en_o       = r_rx_en;
    assign rx_width_o    = r_rx_width;
    assign irq_o         = r_irq;

endmodule
